// File: rtl/flanger_pkg.sv
// rtl/flanger_pkg.sv - shared types, default parameters and saturation helper for the flanger core
package flanger_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READ  = 2'd2,
    MIX   = 2'd3
  } state_t;

  localparam int DEF_W          = 16;
  localparam int DEF_CH         = 2;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_BASE_DELAY = 4;
  localparam int DEF_SWEEP      = 32;
  localparam int DEF_LFO_DIV    = 256;
  localparam int DEF_FB_SHIFT   = 1;

  // Clamp a sign-extended value into the signed range of a w-bit sample.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/flanger_mod_delay_if.sv
// rtl/flanger_mod_delay_if.sv - sample-strobed control/data bundle between the audio path and the flanger core
interface flanger_mod_delay_if #(
  parameter int W  = 16,
  parameter int CH = 2
);
  logic              sample_strobe;
  logic              flanger_en;
  logic              mem_clr;
  logic [CH*W-1:0]   input_data;
  logic [CH*W-1:0]   output_data;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output sample_strobe, flanger_en, mem_clr, input_data,
    input  output_data, out_valid, busy, overrun
  );

  modport slave (
    input  sample_strobe, flanger_en, mem_clr, input_data,
    output output_data, out_valid, busy, overrun
  );
endinterface

// File: rtl/flanger_lfo.sv
// rtl/flanger_lfo.sv - triangle LFO sweeping 0..SWEEP..0, one step every LFO_DIV accepted samples
module flanger_lfo #(
  parameter int SWEEP   = 32,
  parameter int LFO_DIV = 256
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         step,
  input  logic                         flanger_en,
  output logic [$clog2(SWEEP+1)-1:0]   lfo_pos
);
  localparam int POS_W = $clog2(SWEEP + 1);
  localparam int CNT_W = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;

  logic [CNT_W-1:0] lfo_div_cnt;
  logic             lfo_down;

  // The sweep freezes in bypass so the tap resumes where it left off.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lfo_div_cnt <= '0;
      lfo_pos     <= '0;
      lfo_down    <= 1'b0;
    end else if (step && flanger_en) begin
      if (lfo_div_cnt == CNT_W'(LFO_DIV - 1)) begin
        lfo_div_cnt <= '0;
        if (!lfo_down) begin
          lfo_pos <= lfo_pos + POS_W'(1);
          if (lfo_pos == POS_W'(SWEEP - 1)) lfo_down <= 1'b1;
        end else begin
          lfo_pos <= lfo_pos - POS_W'(1);
          if (lfo_pos == POS_W'(1)) lfo_down <= 1'b0;
        end
      end else begin
        lfo_div_cnt <= lfo_div_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/flanger_mod_delay.sv
// rtl/flanger_mod_delay.sv - modulated-delay flanger: circular frame buffer, LFO-swept tap, dry/wet average
// Build option FLANGER_FEEDBACK_EN: buffer stores sat(x + (d >>> FB_SHIFT)) instead of x while the effect is on.
module flanger_mod_delay
  import flanger_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int CH         = DEF_CH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int BASE_DELAY = DEF_BASE_DELAY,
  parameter int SWEEP      = DEF_SWEEP,
  parameter int LFO_DIV    = DEF_LFO_DIV
`ifdef FLANGER_FEEDBACK_EN
  ,
  parameter int FB_SHIFT   = DEF_FB_SHIFT
`endif
) (
  input logic                clk,
  input logic                n_rst,
  flanger_mod_delay_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int POS_W  = $clog2(SWEEP + 1);

  state_t            state, next_state;
  logic [CH*W-1:0]   x_reg, d_reg, y_mix, wr_val;
  logic [CH*W-1:0]   out_data_q;
  logic              out_valid_q, overrun_q;
  logic [ADDR_W-1:0] wr_ptr, rd_addr, clr_addr, tap_addr;
  logic [POS_W-1:0]  lfo_pos;
  logic              mix_step;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CH*W-1:0]   mem_wdata;
  logic [CH*W-1:0]   mem [DEPTH];

  assign mix_step = (state == MIX);
  // Delay is always >= 1 frame, so the tap can never land on the slot being written.
  assign tap_addr = wr_ptr - ADDR_W'(BASE_DELAY) - ADDR_W'(lfo_pos);

  flanger_lfo #(
    .SWEEP   (SWEEP),
    .LFO_DIV (LFO_DIV)
  ) u_lfo (
    .clk        (clk),
    .n_rst      (n_rst),
    .step       (mix_step),
    .flanger_en (bus.flanger_en),
    .lfo_pos    (lfo_pos)
  );

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [W-1:0] xs, ds;
    logic signed [W:0]   sum;
    assign xs  = x_reg[c*W +: W];
    assign ds  = d_reg[c*W +: W];
    assign sum = (W+1)'(xs) + (W+1)'(ds);
    assign y_mix[c*W +: W] = bus.flanger_en ? W'(sum >>> 1) : xs;
`ifdef FLANGER_FEEDBACK_EN
    logic signed [W:0] fb_sum;
    assign fb_sum = (W+1)'(xs) + ((W+1)'(ds) >>> FB_SHIFT);
    assign wr_val[c*W +: W] = bus.flanger_en ? W'(saturate(32'(fb_sum), W)) : xs;
`else
    assign wr_val[c*W +: W] = xs;
`endif
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.mem_clr)            next_state = CLEAR;
        else if (bus.sample_strobe) next_state = READ;
      end
      CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) next_state = IDLE;
      READ:    next_state = MIX;
      MIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_addr     <= '0;
      clr_addr    <= '0;
      x_reg       <= '0;
      d_reg       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= next_state;
      out_valid_q <= 1'b0;
      // A strobe loses to mem_clr in IDLE and is never queued while busy.
      overrun_q   <= bus.sample_strobe && ((state != IDLE) || bus.mem_clr);
      case (state)
        IDLE: begin
          if (bus.mem_clr) begin
            clr_addr <= '0;
          end else if (bus.sample_strobe) begin
            x_reg   <= bus.input_data;
            rd_addr <= tap_addr;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) wr_ptr <= '0;
        end
        READ: d_reg <= mem[rd_addr];
        MIX: begin
          out_data_q  <= y_mix;
          out_valid_q <= 1'b1;
          wr_ptr      <= wr_ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = (state == CLEAR) || (state == MIX);
  assign mem_waddr = (state == CLEAR) ? clr_addr : wr_ptr;
  assign mem_wdata = (state == CLEAR) ? '0 : wr_val;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.output_data = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_flanger_mod_delay.sv
// tb/tb_flanger_mod_delay.sv - self-checking bench: slow-LFO and fast-LFO cores against a frame-level reference model
module tb_flanger_mod_delay;
  localparam int W          = 16;
  localparam int CH         = 2;
  localparam int DEPTH      = 64;
  localparam int BASE_DELAY = 4;
  localparam int SWEEP      = 32;
  localparam int FB_SHIFT   = 1;
  localparam int LFO_SLOW   = 1024;
  localparam int LFO_FAST   = 1;
  localparam int SMAX       = (1 << (W - 1)) - 1;
  localparam int SMIN       = -(1 << (W - 1));

  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int checks   = 0;
  int failures = 0;

  flanger_mod_delay_if #(.W(W), .CH(CH)) bus_s ();
  flanger_mod_delay_if #(.W(W), .CH(CH)) bus_f ();

  assign bus_f.sample_strobe = bus_s.sample_strobe;
  assign bus_f.flanger_en    = bus_s.flanger_en;
  assign bus_f.mem_clr       = bus_s.mem_clr;
  assign bus_f.input_data    = bus_s.input_data;

  flanger_mod_delay #(.W(W), .CH(CH), .DEPTH(DEPTH), .BASE_DELAY(BASE_DELAY),
                      .SWEEP(SWEEP), .LFO_DIV(LFO_SLOW))
    u_dut_slow (.clk(tb_clk), .n_rst(n_rst), .bus(bus_s));

  flanger_mod_delay #(.W(W), .CH(CH), .DEPTH(DEPTH), .BASE_DELAY(BASE_DELAY),
                      .SWEEP(SWEEP), .LFO_DIV(LFO_FAST))
    u_dut_fast (.clk(tb_clk), .n_rst(n_rst), .bus(bus_f));

  // Reference model, index 0 = slow LFO core, 1 = fast LFO core
  int              m_buf [2][DEPTH][CH];
  int              m_wr  [2];
  int              m_pos [2];
  int              m_dir [2];
  int              m_cnt [2];
  logic [CH*W-1:0] exp_y [2];

  logic [1:0]      obs_early, obs_valid, obs_ov;
  logic [CH*W-1:0] obs_s, obs_f;
  int              obs_busy_cnt;

  function automatic int lfo_div(input int i);
    return (i == 0) ? LFO_SLOW : LFO_FAST;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0; m_pos[i] = 0; m_dir[i] = 1; m_cnt[i] = 0;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 0;
      for (int a = 0; a < DEPTH; a++)
        for (int c = 0; c < CH; c++) m_buf[i][a][c] = 0;
    end
  endtask

  task automatic model_sample(input logic [CH*W-1:0] x, input logic en);
    int rd, xv, dv, wv;
    for (int i = 0; i < 2; i++) begin
      rd = (m_wr[i] - BASE_DELAY - m_pos[i] + DEPTH) % DEPTH;
      for (int c = 0; c < CH; c++) begin
        xv = int'($signed(x[c*W +: W]));
        dv = m_buf[i][rd][c];
        exp_y[i][c*W +: W] = en ? W'((xv + dv) >>> 1) : W'(xv);
        wv = xv;
`ifdef FLANGER_FEEDBACK_EN
        if (en) begin
          wv = xv + (dv >>> FB_SHIFT);
          if (wv > SMAX) wv = SMAX;
          if (wv < SMIN) wv = SMIN;
        end
`endif
        m_buf[i][m_wr[i]][c] = wv;
      end
      m_wr[i] = (m_wr[i] + 1) % DEPTH;
      if (en) begin
        m_cnt[i]++;
        if (m_cnt[i] == lfo_div(i)) begin
          m_cnt[i] = 0;
          m_pos[i] += m_dir[i];
          if (m_pos[i] == SWEEP) m_dir[i] = -1;
          else if (m_pos[i] == 0) m_dir[i] = 1;
        end
      end
    end
  endtask

  task automatic drive_sample(input logic [CH*W-1:0] x, input logic en);
    @(negedge tb_clk);
    bus_s.sample_strobe = 1'b1; bus_s.input_data = x; bus_s.flanger_en = en;
    @(negedge tb_clk);
    bus_s.sample_strobe = 1'b0;
    model_sample(x, en);
    @(negedge tb_clk);
    obs_early = {bus_s.out_valid, bus_f.out_valid};
    @(negedge tb_clk);
    obs_valid = {bus_s.out_valid, bus_f.out_valid};
    obs_s = bus_s.output_data; obs_f = bus_f.output_data;
  endtask

  task automatic do_clear(input logic with_strobe);
    @(negedge tb_clk);
    bus_s.mem_clr = 1'b1; bus_s.sample_strobe = with_strobe; bus_s.input_data = $urandom;
    @(negedge tb_clk);
    bus_s.mem_clr = 1'b0; bus_s.sample_strobe = 1'b0;
    obs_ov = {bus_s.overrun, bus_f.overrun};
    obs_busy_cnt = 0;
    while ((bus_s.busy || bus_f.busy) && obs_busy_cnt < 4 * DEPTH) begin
      obs_busy_cnt++;
      @(negedge tb_clk);
    end
    m_clear();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge tb_clk);
    checks++;
    if ({bus_s.output_data, bus_f.output_data} !== '0 ||
        {bus_s.out_valid, bus_s.busy, bus_s.overrun, bus_f.out_valid, bus_f.busy, bus_f.overrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_state data=%h/%h flags=%b%b%b%b%b%b want all zero", bus_s.output_data, bus_f.output_data,
               bus_s.out_valid, bus_s.busy, bus_s.overrun, bus_f.out_valid, bus_f.busy, bus_f.overrun);
    end
    n_rst = 1'b1;
    m_reset();
    do_clear(1'b0);
    drive_sample(32'h1234_5678, 1'b1);
    checks++;
    if (obs_s !== exp_y[0] || obs_f !== exp_y[1]) begin
      failures++;
      $display("FAIL pre_abort_data got=%h/%h want=%h/%h", obs_s, obs_f, exp_y[0], exp_y[1]);
    end
    @(negedge tb_clk);
    bus_s.sample_strobe = 1'b1; bus_s.input_data = $urandom;
    @(negedge tb_clk);
    bus_s.sample_strobe = 1'b0;
    @(negedge tb_clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus_s.output_data, bus_f.output_data} !== '0 ||
        {bus_s.out_valid, bus_s.busy, bus_s.overrun, bus_f.out_valid, bus_f.busy, bus_f.overrun} !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_mix data=%h/%h busy=%b/%b want zero", bus_s.output_data, bus_f.output_data,
               bus_s.busy, bus_f.busy);
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    m_reset();
  endtask

  task automatic test_bypass();
    do_clear(1'b0);
    checks++;
    if (obs_busy_cnt != DEPTH || obs_ov !== 2'b00) begin
      failures++;
      $display("FAIL clear_busy busy_cycles=%0d overrun=%b want %0d/00", obs_busy_cnt, obs_ov, DEPTH);
    end
    drive_sample(32'h9999_1111, 1'b0);
    checks++;
    if (obs_early !== 2'b00 || obs_valid !== 2'b11 || obs_s !== 32'h9999_1111 || obs_f !== 32'h9999_1111) begin
      failures++;
      $display("FAIL bypass valid=%b/%b data=%h/%h want 00/11 99991111", obs_early, obs_valid, obs_s, obs_f);
    end
  endtask

  task automatic test_static_tap();
    logic [CH*W-1:0] want;
    do_clear(1'b0);
    for (int n = 0; n < 16; n++) begin
      drive_sample((n < 8) ? 32'h2222_3333 : 32'h8000_8000, 1'b1);
      want = (n < 4) ? 32'h1111_1999 : (n < 8) ? 32'h2222_3333 : (n >= 12) ? 32'h8000_8000 : exp_y[0];
      checks++;
      if (obs_early !== 2'b00 || obs_valid !== 2'b11 || obs_s !== want || obs_s !== exp_y[0] || obs_f !== exp_y[1]) begin
        failures++;
        $display("FAIL static_tap n=%0d valid=%b/%b got=%h/%h want=%h/%h", n, obs_early, obs_valid,
                 obs_s, obs_f, want, exp_y[1]);
      end
    end
  endtask

  task automatic test_sweep();
    do_clear(1'b0);
    for (int n = 0; n < 140; n++) begin
      drive_sample((n == 0) ? 32'h4000_4000 : 32'h0, 1'b1);
      checks++;
      if (obs_valid !== 2'b11 || obs_s !== exp_y[0] || obs_f !== exp_y[1]) begin
        failures++;
        $display("FAIL sweep_impulse n=%0d valid=%b got=%h/%h want=%h/%h", n, obs_valid, obs_s, obs_f, exp_y[0], exp_y[1]);
      end
    end
  endtask

  task automatic test_random();
    logic en;
    for (int n = 0; n < 160; n++) begin
      en = ($urandom_range(0, 7) != 0);
      drive_sample($urandom, en);
      checks++;
      if (obs_early !== 2'b00 || obs_valid !== 2'b11 || obs_s !== exp_y[0] || obs_f !== exp_y[1]) begin
        failures++;
        $display("FAIL random n=%0d en=%b valid=%b/%b got=%h/%h want=%h/%h", n, en, obs_early, obs_valid,
                 obs_s, obs_f, exp_y[0], exp_y[1]);
      end
    end
  endtask

  task automatic test_overrun();
    logic [CH*W-1:0] a;
    logic [CH*W-1:0] got_s, got_f;
    int ov_s, ov_f, v_s, v_f;
    a = $urandom;
    @(negedge tb_clk);
    bus_s.sample_strobe = 1'b1; bus_s.input_data = a; bus_s.flanger_en = 1'b1;
    @(negedge tb_clk);
    bus_s.input_data = ~a;
    model_sample(a, 1'b1);
    @(negedge tb_clk);
    bus_s.sample_strobe = 1'b0;
    ov_s = 0; ov_f = 0; v_s = 0; v_f = 0; got_s = '0; got_f = '0;
    for (int i = 0; i < 6; i++) begin
      ov_s += int'(bus_s.overrun); ov_f += int'(bus_f.overrun);
      if (bus_s.out_valid) begin v_s++; got_s = bus_s.output_data; end
      if (bus_f.out_valid) begin v_f++; got_f = bus_f.output_data; end
      @(negedge tb_clk);
    end
    checks++;
    if (ov_s != 1 || ov_f != 1 || v_s != 1 || v_f != 1) begin
      failures++;
      $display("FAIL overrun_pulses overrun=%0d/%0d out_valid=%0d/%0d want 1/1 1/1", ov_s, ov_f, v_s, v_f);
    end
    checks++;
    if (got_s !== exp_y[0] || got_f !== exp_y[1]) begin
      failures++;
      $display("FAIL overrun_data got=%h/%h want=%h/%h", got_s, got_f, exp_y[0], exp_y[1]);
    end
    do_clear(1'b1);
    checks++;
    if (obs_ov !== 2'b11 || obs_busy_cnt != DEPTH) begin
      failures++;
      $display("FAIL clr_strobe overrun=%b busy_cycles=%0d want 11/%0d", obs_ov, obs_busy_cnt, DEPTH);
    end
  endtask

`ifdef FLANGER_FEEDBACK_EN
  task automatic test_feedback();
    do_clear(1'b0);
    for (int n = 0; n < 13; n++) begin
      drive_sample((n == 0) ? 32'h4000_4000 : 32'h0, 1'b1);
      checks++;
      if (obs_s !== exp_y[0] || obs_f !== exp_y[1] ||
          (n == 4 && obs_s !== 32'h2000_2000) || (n == 8 && obs_s !== 32'h1000_1000)) begin
        failures++;
        $display("FAIL feedback_echo n=%0d got=%h/%h want=%h/%h", n, obs_s, obs_f, exp_y[0], exp_y[1]);
      end
    end
    do_clear(1'b0);
    for (int n = 0; n < 16; n++) begin
      drive_sample(32'h7FFF_7FFF, 1'b1);
      checks++;
      if (obs_s !== exp_y[0] || obs_f !== exp_y[1] || (n >= 4 && obs_s !== 32'h7FFF_7FFF)) begin
        failures++;
        $display("FAIL feedback_sat n=%0d got=%h/%h want=%h/%h", n, obs_s, obs_f, exp_y[0], exp_y[1]);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog bench did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_s.sample_strobe = 1'b0;
    bus_s.flanger_en    = 1'b1;
    bus_s.mem_clr       = 1'b0;
    bus_s.input_data    = '0;
    obs_early = '0; obs_valid = '0; obs_ov = '0; obs_s = '0; obs_f = '0; obs_busy_cnt = 0;
    m_reset();
    m_clear();
    test_reset();
    test_bypass();
    test_static_tap();
    test_sweep();
    test_random();
    test_overrun();
`ifdef FLANGER_FEEDBACK_EN
    test_feedback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flanger_mod_delay.md
Name: flanger_mod_delay

Overview:
Parametrised modulated-delay effect, the next-generation flanger core for the audio path. It runs at the 1.4112 MHz system clock (32x 44.1 kHz) and is sample-strobed. It stores CH-channel signed frames in an internal circular buffer and sweeps the read tap with a triangle LFO. Each output is the average of the dry sample and the delayed sample. Supports bypass, sequential buffer clear and overrun detection.

Parameters:
W, 16, bits per channel sample (signed two's complement)
CH, 2, channel count; channel c occupies bits [c*W +: W]
DEPTH, 64, buffer depth in frames (power of 2); ADDR_W = $clog2(DEPTH) is derived
BASE_DELAY, 4, minimum tap delay in frames (>=1)
SWEEP, 32, LFO peak; BASE_DELAY+SWEEP <= DEPTH-1
LFO_DIV, 256, accepted samples per LFO step (>=1)
FB_SHIFT, 1, feedback attenuation shift (used only with the optional feature)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
sample_strobe  in  1  one-cycle pulse: input_data is valid
flanger_en  in  1  1 = effect, 0 = bypass
mem_clr  in  1  pulse: zero the whole buffer
input_data  in  CH*W  packed input frame
output_data  out  CH*W  packed output frame (registered)
out_valid  out  1  one-cycle pulse: output_data updated
busy  out  1  high in any non-IDLE state
overrun  out  1  one-cycle pulse: strobe dropped

Behaviour:
- Reset: output_data=0, out_valid=0, busy=0, overrun=0, wr_ptr=0, lfo_pos=0, lfo_dir=up, lfo_div_cnt=0, state=IDLE. Reset does not clear buffer contents; mem_clr must be issued after reset.
- FSM states: IDLE, CLEAR, READ, MIX.
- IDLE: mem_clr -> CLEAR (mem_clr wins over a simultaneous strobe; that strobe is dropped, overrun pulses). Else sample_strobe -> latch x=input_data, rd_addr = (wr_ptr - (BASE_DELAY+lfo_pos)) mod DEPTH -> READ.
- READ: d = buf[rd_addr] -> MIX.
- MIX: per channel, y = (x + d) >>> 1, computed in W+1 bits and truncated to W (no overflow possible). When flanger_en=0, y = x. Register output_data=y and pulse out_valid. Write buf[wr_ptr] = x. Increment wr_ptr mod DEPTH. Advance LFO only if flanger_en=1. -> IDLE.
- Latency: strobe sampled at edge k; output_data/out_valid update at edge k+2. Minimum strobe spacing is 3 cycles.
- LFO: lfo_div_cnt counts accepted samples 0..LFO_DIV-1. On wrap, lfo_pos steps +/-1. Direction flips on reaching SWEEP (up) or 0 (down). Sequence: 0,1..SWEEP,SWEEP-1..0,1...
- The tap never equals wr_ptr because delay >= 1, so there is no read/write collision.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle (DEPTH cycles), sets wr_ptr=0, then -> IDLE. LFO is not reset. mem_clr during CLEAR is ignored.
- sample_strobe in any non-IDLE state is dropped and overrun pulses the next cycle. FSM state is unaffected.
- output_data holds its value between out_valid pulses.
- n_rst asserted mid-operation aborts immediately to the reset values. A partial CLEAR leaves the buffer undefined.

Optional Feature:
FLANGER_FEEDBACK_EN
- Defined: in MIX, the buffer write value is sat_W(x + (d >>> FB_SHIFT)), computed in W+1 bits. Result is clamped to [-2^(W-1), 2^(W-1)-1]. Feedback applies only when flanger_en=1; in bypass, x is written.
- Undefined: the buffer write value is always x, and FB_SHIFT is unused.

Decomposition:
- Package flanger_pkg holds:
  - state enum (IDLE, CLEAR, READ, MIX)
  - default parameter constants
  - saturate function used by the feedback path
- Sub-module flanger_lfo: triangle generator with parameters SWEEP and LFO_DIV. Inputs: step enable, flanger_en. Output: lfo_pos.

Test Plan:
- Reset: assert n_rst=0 mid-MIX -> output_data=0, out_valid=0, busy=0, overrun=0 while reset is held.
- Bypass: mem_clr, wait busy=0 (64 cycles); flanger_en=0, strobe with input 0x99991111 -> out_valid at edge+2, output_data=0x99991111.
- Static tap, LFO_DIV=1024: after clear, strobe constant 0x22223333 every 32 cycles -> first 4 outputs 0x11111999, 5th onward 0x22223333. Then input 0x80008000 on both buffer and dry -> 0x80008000.
- Sweep, LFO_DIV=1: write a single impulse 0x00010001 into zeros -> the impulse reappears at delays following 4,5..36,35..; a checker model matches every frame.
- Overrun: strobes on 2 consecutive cycles -> second dropped, one overrun pulse, one out_valid. Strobe coinciding with mem_clr -> dropped, overrun pulses.
- Feedback (FLANGER_FEEDBACK_EN, FB_SHIFT=1): impulse 0x40004000 -> echoes of 0x2000-derived decaying values every 4 frames. Input 0x7FFF7FFF sustained -> buffer saturates at 0x7FFF, no wrap.
